addsub_serial: RTL and testbench

Parametrised, digit-serial two's-complement adder/subtractor. Processes DIGIT bits per clock, LSB digit first, through a single DIGIT-bit ripple slice. Uses a start/busy/done handshake and registers the result plus status flags (carry, overflow, zero, negative). Sits in the datapath labs as the multi-cycle, width-generic successor of the 4-bit combinational add/sub unit, trading latency for area.

---
 rtl/addsub_serial.sv | 143 ++++++++++++++
 tb/tb_addsub_serial.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per cycle, LSB digit first.
// Optional macro ADDSUB_SATURATE_EN clamps the result on signed overflow.
`timescale 1ns/1ps
module addsub_serial #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             m,
  input  logic             c_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             v,
  output logic             z,
  output logic             n
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DW    = DIGIT + 1;

  generate
    if (WIDTH < 2 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("addsub_serial: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_d;
  logic   accept, last;

  logic [WIDTH-1:0] a_sr, b_sr, acc;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic [DW-1:0]    dsum;
  logic [WIDTH-1:0] acc_shift;
  logic [WIDTH-1:0] s_fin;
  logic             c_msb;
  logic             v_raw;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state and control decode
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt == CNT_W'(N - 1)) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One ripple slice; on the last digit its top bit is the operand MSB
  always_comb begin
    dsum      = DW'(a_sr[DIGIT-1:0]) + DW'(b_sr[DIGIT-1:0]) + DW'(carry);
    acc_shift = WIDTH'({dsum[DIGIT-1:0], acc} >> DIGIT);
    c_msb     = a_sr[DIGIT-1] ^ b_sr[DIGIT-1] ^ dsum[DIGIT-1];
    v_raw     = c_msb ^ dsum[DIGIT];
`ifdef ADDSUB_SATURATE_EN
    if (v_raw) s_fin = a_sr[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else       s_fin = acc_shift;
`else
    s_fin = acc_shift;
`endif
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      c_out <= 1'b0;
      v     <= 1'b0;
      z     <= 1'b0;
      n     <= 1'b0;
    end else begin
      busy <= (state_d == RUN);
      done <= (state_d == DONE);
      if (accept) begin
        a_sr  <= a;
        b_sr  <= b ^ {WIDTH{m}};
        carry <= c_in;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sr  <= a_sr >> DIGIT;
        b_sr  <= b_sr >> DIGIT;
        carry <= dsum[DIGIT];
        acc   <= acc_shift;
        cnt   <= cnt + CNT_W'(1);
        if (last) begin
          s     <= s_fin;
          c_out <= dsum[DIGIT];
          v     <= v_raw;
          z     <= (s_fin == '0);
          n     <= s_fin[WIDTH-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench for addsub_serial across W8/D2, W8/D1, W8/D8 and W16/D4 instances.
// Expected values follow the ADDSUB_SATURATE_EN build setting.
`timescale 1ns/1ps
module tb_addsub_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  start_v;
  logic        m_i, c_i;
  logic [15:0] a_i, b_i;

  logic [3:0]  busy_v, done_v, co_v, v_v, z_v, n_v;
  logic [7:0]  s8 [3];
  logic [15:0] s16;
  logic [15:0] s_v [4];

  typedef struct {
    int          k;
    logic [15:0] s;
    logic        c, v, z, n;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   bcnt [4];

  always #5 clk = ~clk;

  addsub_serial #(.WIDTH(8), .DIGIT(2)) u_d0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .m(m_i), .c_in(c_i),
    .a(a_i[7:0]), .b(b_i[7:0]), .busy(busy_v[0]), .done(done_v[0]), .s(s8[0]),
    .c_out(co_v[0]), .v(v_v[0]), .z(z_v[0]), .n(n_v[0]));
  addsub_serial #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .m(m_i), .c_in(c_i),
    .a(a_i[7:0]), .b(b_i[7:0]), .busy(busy_v[1]), .done(done_v[1]), .s(s8[1]),
    .c_out(co_v[1]), .v(v_v[1]), .z(z_v[1]), .n(n_v[1]));
  addsub_serial #(.WIDTH(8), .DIGIT(8)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .m(m_i), .c_in(c_i),
    .a(a_i[7:0]), .b(b_i[7:0]), .busy(busy_v[2]), .done(done_v[2]), .s(s8[2]),
    .c_out(co_v[2]), .v(v_v[2]), .z(z_v[2]), .n(n_v[2]));
  addsub_serial #(.WIDTH(16), .DIGIT(4)) u_d3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .m(m_i), .c_in(c_i),
    .a(a_i), .b(b_i), .busy(busy_v[3]), .done(done_v[3]), .s(s16),
    .c_out(co_v[3]), .v(v_v[3]), .z(z_v[3]), .n(n_v[3]));

  assign s_v[0] = {8'h00, s8[0]};
  assign s_v[1] = {8'h00, s8[1]};
  assign s_v[2] = {8'h00, s8[2]};
  assign s_v[3] = s16;

  function automatic int cycles_of(input int k);
    case (k)
      0: return 4;
      1: return 8;
      2: return 1;
      default: return 4;
    endcase
  endfunction

  // Monitor: pop one expectation per done pulse and check busy length
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst_n) begin
        bcnt[k] = 0;
      end else begin
        if (busy_v[k]) bcnt[k]++;
        if (done_v[k]) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done dut%0d: got s=%h with no pending operation", k, s_v[k]);
          end else begin
            exp_t e;
            e = q.pop_front();
            if (e.k != k || s_v[k] != e.s || co_v[k] != e.c || v_v[k] != e.v ||
                z_v[k] != e.z || n_v[k] != e.n || busy_v[k] != 1'b0) begin
              errors++;
              $display("FAIL result dut%0d: got s=%h c=%b v=%b z=%b n=%b busy=%b, want dut%0d s=%h c=%b v=%b z=%b n=%b busy=0",
                       k, s_v[k], co_v[k], v_v[k], z_v[k], n_v[k], busy_v[k], e.k, e.s, e.c, e.v, e.z, e.n);
            end
          end
          checks++;
          if (bcnt[k] != cycles_of(k)) begin
            errors++;
            $display("FAIL busy_len dut%0d: got %0d cycles, want %0d", k, bcnt[k], cycles_of(k));
          end
          bcnt[k] = 0;
        end
      end
    end
  end

  task automatic check_idle_zero(input int k, input string tag);
    checks++;
    if (busy_v[k] !== 1'b0 || done_v[k] !== 1'b0 || s_v[k] !== 16'h0 || co_v[k] !== 1'b0 ||
        v_v[k] !== 1'b0 || z_v[k] !== 1'b0 || n_v[k] !== 1'b0) begin
      errors++;
      $display("FAIL %s dut%0d: got busy=%b done=%b s=%h c=%b v=%b z=%b n=%b, want all zero",
               tag, k, busy_v[k], done_v[k], s_v[k], co_v[k], v_v[k], z_v[k], n_v[k]);
    end
  endtask

  task automatic wait_done(input int k);
    for (int i = 0; i < 40; i++) begin
      if (done_v[k]) return;
      @(posedge clk); #1;
    end
    checks++;
    errors++;
    $display("FAIL timeout dut%0d: got no done within 40 cycles, want done pulse", k);
  endtask

  // Launch one operation; push the expected result; optionally stay in the DONE cycle
  task automatic op(input int k, input logic [15:0] ta, input logic [15:0] tb, input logic tm,
                    input logic tc, input logic [15:0] es, input logic ec, input logic ev,
                    input logic ez, input logic en, input bit stay, input bit robust);
    exp_t e;
    e.k = k; e.s = es; e.c = ec; e.v = ev; e.z = ez; e.n = en;
    a_i = ta; b_i = tb; m_i = tm; c_i = tc;
    start_v[k] = 1'b1;
    q.push_back(e);
    @(posedge clk); #1;
    if (robust) begin
      a_i = ~ta; b_i = ~tb; m_i = ~tm; c_i = ~tc;
      @(posedge clk); #1;
    end
    start_v[k] = 1'b0;
    a_i = 16'hA5C3; b_i = 16'h3C5A; m_i = ~tm; c_i = ~tc;
    wait_done(k);
    if (!stay) begin
      @(posedge clk); #1;
    end
  endtask

  // Start an operation, then pulse reset during RUN; no done may follow
  task automatic reset_mid(input int k, input int rcyc);
    a_i = 16'h7F7F; b_i = 16'h0101; m_i = 1'b0; c_i = 1'b0;
    start_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    repeat (rcyc) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_idle_zero(k, "reset_mid");
    repeat (10) begin
      @(posedge clk); #1;
    end
    check_idle_zero(k, "reset_hold");
  endtask

  task automatic plan8(input int k, input int rcyc);
    op(k, 16'h35, 16'h12, 1'b0, 1'b0, 16'h47, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    op(k, 16'h10, 16'h01, 1'b1, 1'b1, 16'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ADDSUB_SATURATE_EN
    op(k, 16'h7F, 16'h01, 1'b0, 1'b0, 16'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    op(k, 16'h80, 16'h01, 1'b1, 1'b1, 16'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
`else
    op(k, 16'h7F, 16'h01, 1'b0, 1'b0, 16'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    op(k, 16'h80, 16'h01, 1'b1, 1'b1, 16'h7F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
`endif
    op(k, 16'h05, 16'h05, 1'b1, 1'b1, 16'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    op(k, 16'h35, 16'h12, 1'b0, 1'b0, 16'h47, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset_mid(k, rcyc);
    op(k, 16'hFF, 16'h01, 1'b0, 1'b0, 16'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic plan16();
    op(3, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    op(3, 16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef ADDSUB_SATURATE_EN
    op(3, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    op(3, 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
`else
    op(3, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    op(3, 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
`endif
    op(3, 16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    op(3, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset_mid(3, 1);
    op(3, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start_v = '0;
    a_i = '0; b_i = '0; m_i = 1'b0; c_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) check_idle_zero(k, "reset_state");

    plan8(0, 1);
    plan8(1, 1);
    plan8(2, 0);
    plan16();

    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending: got %0d operations without done, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
